// File: rtl/tft_spi_sniffer.sv
// Passive sniffer for a 4-wire SPI TFT panel bus: recovers bytes, commands and
// addressed RGB565 pixels from CASET/PASET/RAMWR traffic in the clk domain.
module tft_spi_sniffer #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 479
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_dc,
    input  logic        spi_cs,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pixel_valid,
    output logic [8:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [15:0] pixel_color,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, SKIP} state_t;

    logic [1:0] clk_sync, mosi_sync, dc_sync, cs_sync;
    logic       clk_prev;
    logic       sclk_rise;

    // cs synchronizer resets to deselected so no bits are taken before the bus is seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b00;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
            cs_sync   <= 2'b11;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            dc_sync   <= {dc_sync[0], spi_dc};
            cs_sync   <= {cs_sync[0], spi_cs};
            clk_prev  <= clk_sync[1];
        end
    end

    assign sclk_rise = clk_sync[1] & ~clk_prev;

    logic [2:0] bit_cnt;
    logic [6:0] shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'd0;
            byte_dc    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 8'd0;
        end else begin
            byte_valid <= 1'b0;
            cmd_valid  <= 1'b0;
            if (cs_sync[1]) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg, mosi_sync[1]};
                    byte_dc    <= dc_sync[1];
                    if (!dc_sync[1]) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= {shreg, mosi_sync[1]};
                    end
                end
                shreg   <= {shreg[5:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    state_t      state;
    logic [1:0]  arg_cnt;
    logic [23:0] arg;
    logic [15:0] xs, xe, ys, ye;
    logic [15:0] cur_x, cur_y;
    logic        half;
    logic [7:0]  hi;
    logic [15:0] win_lo, win_hi;

    // first three window bytes are held in arg; the fourth arrives as byte_data
    assign win_lo = arg[23:8];
    assign win_hi = {arg[7:0], byte_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            arg_cnt     <= 2'd0;
            arg         <= 24'd0;
            xs          <= 16'd0;
            xe          <= 16'(X_MAX);
            ys          <= 16'd0;
            ye          <= 16'(Y_MAX);
            cur_x       <= 16'd0;
            cur_y       <= 16'd0;
            half        <= 1'b0;
            hi          <= 8'd0;
            pixel_valid <= 1'b0;
            pixel_x     <= 9'd0;
            pixel_y     <= 9'd0;
            pixel_color <= 16'd0;
            error       <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            if (byte_valid && !byte_dc) begin
                half    <= 1'b0;
                arg_cnt <= 2'd0;
                case (byte_data)
                    8'h2A:   state <= CASET;
                    8'h2B:   state <= PASET;
                    8'h2C: begin
                        state <= RAMWR;
                        cur_x <= xs;
                        cur_y <= ys;
                    end
                    8'h00:   state <= IDLE;
                    default: state <= SKIP;
                endcase
            end else if (byte_valid) begin
                case (state)
                    IDLE: error <= 1'b1;
                    CASET, PASET: begin
                        if (arg_cnt == 2'd3) begin
                            state   <= IDLE;
                            arg_cnt <= 2'd0;
                            if (win_lo > win_hi) begin
                                error <= 1'b1;
                            end else if (state == CASET) begin
                                xs <= win_lo;
                                xe <= win_hi;
                            end else begin
                                ys <= win_lo;
                                ye <= win_hi;
                            end
                        end else begin
                            arg     <= {arg[15:0], byte_data};
                            arg_cnt <= arg_cnt + 2'd1;
                        end
                    end
                    RAMWR: begin
                        if (!half) begin
                            hi   <= byte_data;
                            half <= 1'b1;
                        end else begin
                            half        <= 1'b0;
                            pixel_valid <= 1'b1;
                            pixel_color <= {hi, byte_data};
                            pixel_x     <= cur_x[8:0];
                            pixel_y     <= cur_y[8:0];
                            if (cur_x == xe) begin
                                cur_x <= xs;
                                cur_y <= (cur_y == ye) ? ys : cur_y + 16'd1;
                            end else begin
                                cur_x <= cur_x + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
